ball: RTL and testbench
=======================

BALL -- requirements
Module: ball

Interface
- REQ-001 Parameter B_SIZE, default 4: half the ball side, in pixels.
- REQ-002 Parameter IX, default 320: ball centre X at serve.
- REQ-003 Parameter IY, default 240: ball centre Y at serve.
- REQ-004 Parameter D_WIDTH, default 640: display width. Parameter D_HEIGHT, default 480: display height.
- REQ-005 Port i_clk, input, 1 bit: the only clock. Port i_rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006 Port i_ani_stb, input, 1 bit: animation step strobe. Port i_animate, input, 1 bit: steps are taken only while this is high.
- REQ-007 Port i_start, input, 1 bit: serve or restart request.
- REQ-008 Ports i_px1 and i_px2, input, 12 bits each: paddle left and right edges. Port i_py1, input, 12 bits: paddle top edge.
- REQ-009 Ports o_x1, o_x2, o_y1, o_y2, output, 12 bits each: ball left, right, top and bottom edges.
- REQ-010 Port o_hit, output, 1 bit: paddle-hit pulse. Port o_score, output, 9 bits: hit count. Port o_endgame, output, 1 bit: ball missed.

Function
- REQ-011 Internal state: 12-bit centre x and y; x_dir (0 = left, 1 = right); y_dir (0 = up, 1 = down).
- REQ-012 Edge outputs are combinational: o_x1 = x-B_SIZE, o_x2 = x+B_SIZE, o_y1 = y-B_SIZE, o_y2 = y+B_SIZE.
- REQ-013 FSM has three states: IDLE, PLAY, OVER.
- REQ-014 IDLE: x=IX, y=IY, x_dir=1, y_dir=1. i_start moves to PLAY on the next cycle and clears o_score to 0 on that same edge.
- REQ-015 A step is a cycle in PLAY with i_ani_stb=1 and i_animate=1. At a step: x_next = x±1 and y_next = y±1 according to direction, and x, y are loaded with x_next, y_next.
- REQ-016 i_animate=0 or i_ani_stb=0 holds all state unchanged.
- REQ-017 Left wall: x_dir=0 and x_next==B_SIZE gives x_dir←1. Right wall: x_dir=1 and x_next==D_WIDTH-1-B_SIZE gives x_dir←0.
- REQ-018 Top wall: y_dir=0 and y_next==B_SIZE gives y_dir←1.
- REQ-019 Paddle hit is y_dir=1, y_next+B_SIZE==i_py1, x_next+B_SIZE>=i_px1 and x_next-B_SIZE<=i_px2. On a hit: y_dir←0, o_hit=1 for exactly one cycle, o_score+1 (saturating at 511).
- REQ-020 Miss is y_dir=1 and y_next+B_SIZE==D_HEIGHT-1 with no paddle hit on the same step. On a miss: state←OVER, o_endgame←1.
- REQ-021 Simultaneous conditions: an X flip and a Y flip on one step both apply. A paddle hit takes priority over a miss.
- REQ-022 OVER: position frozen, o_endgame=1. i_start returns to IDLE on the next cycle, which reloads the serve position, clears o_endgame and keeps o_score.
- REQ-023 i_start is ignored in PLAY.
- REQ-024 o_hit is 0 in every cycle other than the one after a hit step.

Reset
- REQ-025 i_rst=1 forces the following on the next edge, in any state including mid-PLAY: state=IDLE, x=IX, y=IY, x_dir=1, y_dir=1, o_score=0, o_hit=0, o_endgame=0.
- REQ-026 After reset, o_x1=IX-B_SIZE, o_x2=IX+B_SIZE, o_y1=IY-B_SIZE, o_y2=IY+B_SIZE.
- REQ-027 Reset has priority over i_start and over steps.

Configuration
- REQ-028 Macro BALL_AUTOSERVE_EN defined: an 8-bit counter clears on entry to OVER and counts i_ani_stb pulses while in OVER. The block returns to IDLE when the count reaches 120, or earlier on i_start.
- REQ-029 Macro BALL_AUTOSERVE_EN undefined: no counter exists, and OVER leaves only on i_start or i_rst.

Structure
- REQ-030 Shared package breakout_pkg holds the FSM state enum (IDLE, PLAY, OVER), the coordinate width 12, and the D_WIDTH/D_HEIGHT defaults.
- REQ-031 There is no sub-module. Step and collision arithmetic is inline in ball.

Verification
- REQ-032 Reset, then i_start, then 1 step: x=321, y=241, o_x1=317, o_y2=245, o_score=0.
- REQ-033 Paddle i_px1=480, i_px2=540, i_py1=440; serve, then 196 steps: y=436, x=516, o_hit high for one cycle, o_score=1, y decreases on step 197.
- REQ-034 Paddle i_px1=0, i_px2=60, i_py1=440; serve, then 235 steps: y=475, x=555, o_endgame=1, o_hit never asserted, position frozen under further strobes.
- REQ-035 PLAY with i_animate=0 and 50 strobes: x, y unchanged. Then i_rst mid-PLAY: next cycle is IDLE, x=320, y=240, o_score=0.
- REQ-036 With BALL_AUTOSERVE_EN, after a miss: 119 strobes keeps OVER; the 120th strobe gives IDLE with o_endgame=0 and o_score held. Without the macro: 200 strobes keeps OVER.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game blocks: coordinate width,
// display defaults, FSM state encoding and a saturating score helper.
package breakout_pkg;

    localparam int COORD_W      = 12;
    localparam int SCORE_W      = 9;
    localparam int D_WIDTH_DEF  = 640;
    localparam int D_HEIGHT_DEF = 480;
    localparam int SERVE_CNT    = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] v
    );
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/ball.sv
// Breakout ball: moves one pixel diagonally per animation step, bounces off
// walls and the paddle, counts paddle hits and flags a miss.
// Ports: i_clk/i_rst (sync, active-high), i_ani_stb/i_animate step control,
// i_start serve/restart, i_px1/i_px2/i_py1 paddle edges, o_x1..o_y2 ball
// edges, o_hit one-cycle hit pulse, o_score hit count, o_endgame miss flag.
// Optional macro BALL_AUTOSERVE_EN: leave OVER after 120 strobes.
module ball
    import breakout_pkg::*;
#(
    parameter int B_SIZE   = 4,
    parameter int IX       = 320,
    parameter int IY       = 240,
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int D_HEIGHT = D_HEIGHT_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ani_stb,
    input  logic               i_animate,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_px1,
    input  logic [COORD_W-1:0] i_px2,
    input  logic [COORD_W-1:0] i_py1,
    output logic [COORD_W-1:0] o_x1,
    output logic [COORD_W-1:0] o_x2,
    output logic [COORD_W-1:0] o_y1,
    output logic [COORD_W-1:0] o_y2,
    output logic               o_hit,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_endgame
);

    localparam logic [COORD_W-1:0] BS    = COORD_W'(B_SIZE);
    localparam logic [COORD_W-1:0] SX    = COORD_W'(IX);
    localparam logic [COORD_W-1:0] SY    = COORD_W'(IY);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(D_WIDTH - 1 - B_SIZE);
    localparam logic [COORD_W-1:0] Y_BOT = COORD_W'(D_HEIGHT - 1);

    state_t             state, state_next;
    logic [COORD_W-1:0] x, y;
    logic [COORD_W-1:0] x_next, y_next;
    logic               x_dir, y_dir;
    logic               step, hit, miss;
    logic               serve_load;
    logic               auto_srv;
    logic               hit_q;
    logic [SCORE_W-1:0] score;

    assign step   = (state == PLAY) && i_ani_stb && i_animate;
    assign x_next = x_dir ? x + COORD_W'(1) : x - COORD_W'(1);
    assign y_next = y_dir ? y + COORD_W'(1) : y - COORD_W'(1);

    // Paddle overlap is tested on the bottom edge of the ball only
    assign hit  = y_dir
               && (y_next + BS == i_py1)
               && (x_next + BS >= i_px1)
               && (x_next - BS <= i_px2);
    assign miss = y_dir && (y_next + BS == Y_BOT) && !hit;

`ifdef BALL_AUTOSERVE_EN
    logic [7:0] srv_cnt;

    // Counter restarts every time OVER is entered
    always_ff @(posedge i_clk) begin
        if (i_rst || state != OVER)
            srv_cnt <= '0;
        else if (i_ani_stb)
            srv_cnt <= srv_cnt + 8'd1;
    end

    assign auto_srv = (state == OVER) && i_ani_stb
                   && (srv_cnt == 8'(SERVE_CNT - 1));
`else
    assign auto_srv = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next state
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (i_start) state_next = PLAY;
            PLAY:    if (step && miss) state_next = OVER;
            OVER:    if (i_start || auto_srv) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_endgame  = (state == OVER);
        serve_load = (state == IDLE)
                  || (state == OVER && state_next == IDLE);
    end

    // Position, direction and score
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x     <= SX;
            y     <= SY;
            x_dir <= 1'b1;
            y_dir <= 1'b1;
            hit_q <= 1'b0;
            score <= '0;
        end else begin
            hit_q <= step && hit;
            if (serve_load) begin
                x     <= SX;
                y     <= SY;
                x_dir <= 1'b1;
                y_dir <= 1'b1;
            end else if (step) begin
                x <= x_next;
                y <= y_next;
                if (!x_dir && x_next == BS)
                    x_dir <= 1'b1;
                else if (x_dir && x_next == X_MAX)
                    x_dir <= 1'b0;
                if (!y_dir && y_next == BS)
                    y_dir <= 1'b1;
                else if (hit)
                    y_dir <= 1'b0;
            end
            if (state == IDLE && i_start)
                score <= '0;
            else if (step && hit)
                score <= sat_inc(score);
        end
    end

    assign o_x1    = x - BS;
    assign o_x2    = x + BS;
    assign o_y1    = y - BS;
    assign o_y2    = y + BS;
    assign o_hit   = hit_q;
    assign o_score = score;

endmodule

// File: tb/tb_ball.sv
// Self-checking bench for ball: directed vector table, hand sequences for
// hit/miss/reset corners, then random stimulus against a behavioural model.
module tb_ball;

    localparam int B = 4;
    localparam int W = 640;
    localparam int H = 480;
`ifdef BALL_AUTOSERVE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ani_stb = 1'b0;
    logic        i_animate = 1'b0;
    logic        i_start = 1'b0;
    logic [11:0] i_px1 = '0;
    logic [11:0] i_px2 = '0;
    logic [11:0] i_py1 = '0;
    logic [11:0] o_x1, o_x2, o_y1, o_y2;
    logic        o_hit;
    logic [8:0]  o_score;
    logic        o_endgame;

    int n_vec = 0;
    int n_bad = 0;
    int hits  = 0;

    // model state: centre, velocity, mode 0=idle 1=play 2=over
    int mx, my, vx, vy, mmode, mscore, mhit, mcnt;

    ball dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ani_stb (i_ani_stb),
        .i_animate (i_animate),
        .i_start   (i_start),
        .i_px1     (i_px1),
        .i_px2     (i_px2),
        .i_py1     (i_py1),
        .o_x1      (o_x1),
        .o_x2      (o_x2),
        .o_y1      (o_y1),
        .o_y2      (o_y2),
        .o_hit     (o_hit),
        .o_score   (o_score),
        .o_endgame (o_endgame)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int px1, px2, py1, n;
        int x1, y1, score, hit, endg;
    } vec_t;

    vec_t tbl[8] = '{
        '{480, 540, 440, 196, 512, 432, 1, 1, 0},
        '{480, 540, 440, 195, 511, 431, 0, 0, 0},
        '{  0,  60, 440, 235, 551, 471, 0, 0, 1},
        '{  0,  60, 440, 234, 550, 470, 0, 0, 0},
        '{100, 512, 440, 196, 512, 432, 1, 1, 0},
        '{100, 511, 440, 196, 512, 432, 0, 0, 0},
        '{520, 600, 440, 196, 512, 432, 1, 1, 0},
        '{521, 600, 440, 196, 512, 432, 0, 0, 0}
    };

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
        if (o_hit) hits++;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
    endtask

    task automatic serve();
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic steps(input int n);
        i_ani_stb = 1'b1;
        i_animate = 1'b1;
        repeat (n) cyc();
        i_ani_stb = 1'b0;
    endtask

    task automatic set_pad(input int a, input int b, input int c);
        i_px1 = 12'(a);
        i_px2 = 12'(b);
        i_py1 = 12'(c);
    endtask

    task automatic serve_pos();
        mx = 320; my = 240; vx = 1; vy = 1;
    endtask

    task automatic model_step(input bit rst, input bit stb,
                              input bit anim, input bit start,
                              input int px1, input int px2,
                              input int py1);
        int nx, ny;
        bit h;
        if (rst) begin
            serve_pos();
            mscore = 0; mhit = 0; mmode = 0; mcnt = 0;
            return;
        end
        mhit = 0;
        case (mmode)
            0: begin
                serve_pos();
                if (start) begin
                    mscore = 0;
                    mmode = 1;
                end
            end
            1: if (stb && anim) begin
                nx = mx + vx;
                ny = my + vy;
                h = vy > 0 && ny + B == py1
                    && nx + B >= px1 && nx - B <= px2;
                if (vx < 0 && nx == B) vx = 1;
                else if (vx > 0 && nx == W - 1 - B) vx = -1;
                if (vy < 0 && ny == B) vy = 1;
                else if (h) begin
                    vy = -1;
                    mhit = 1;
                    if (mscore < 511) mscore++;
                end else if (vy > 0 && ny + B == H - 1) begin
                    mmode = 2;
                    mcnt = 0;
                end
                mx = nx;
                my = ny;
            end
            default: begin
                if (stb) mcnt++;
                if (start || (AUTO && mcnt >= 120)) begin
                    mmode = 0;
                    serve_pos();
                end
            end
        endcase
    endtask

    initial begin
        bit rr, ss, aa, st;
        int pa, pb, pc;

        // reset state
        do_reset();
        chk("rst_x1", o_x1, 316);
        chk("rst_x2", o_x2, 324);
        chk("rst_y1", o_y1, 236);
        chk("rst_y2", o_y2, 244);
        chk("rst_score", o_score, 0);
        chk("rst_hit", o_hit, 0);
        chk("rst_end", o_endgame, 0);

        // first step after serve
        serve();
        steps(1);
        chk("s1_x1", o_x1, 317);
        chk("s1_x2", o_x2, 325);
        chk("s1_y1", o_y1, 237);
        chk("s1_y2", o_y2, 245);
        chk("s1_score", o_score, 0);

        // vector table: serve, n steps, compare
        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_pad(tbl[i].px1, tbl[i].px2, tbl[i].py1);
            serve();
            hits = 0;
            steps(tbl[i].n);
            chk($sformatf("t%0d_x1", i), o_x1, tbl[i].x1);
            chk($sformatf("t%0d_y1", i), o_y1, tbl[i].y1);
            chk($sformatf("t%0d_score", i), o_score, tbl[i].score);
            chk($sformatf("t%0d_hit", i), o_hit, tbl[i].hit);
            chk($sformatf("t%0d_hits", i), hits, tbl[i].hit);
            chk($sformatf("t%0d_end", i), o_endgame, tbl[i].endg);
        end

        // hit pulse width, bounce, then long rally to a miss
        do_reset();
        set_pad(480, 540, 440);
        serve();
        steps(196);
        chk("hp_hit", o_hit, 1);
        cyc();
        chk("hp_hit_low", o_hit, 0);
        chk("hp_hold_y1", o_y1, 432);
        steps(1);
        chk("hp_up_y1", o_y1, 431);
        chk("hp_up_x1", o_x1, 513);
        chk("hp_score", o_score, 1);
        set_pad(480, 540, 1000);
        hits = 0;
        steps(902);
        chk("rally_end", o_endgame, 1);
        chk("rally_x1", o_x1, 153);
        chk("rally_y1", o_y1, 471);
        chk("rally_score", o_score, 1);

        // frozen in OVER under strobes
        i_ani_stb = 1'b1;
        i_animate = 1'b1;
        repeat (119) cyc();
        chk("ov119_end", o_endgame, 1);
        chk("ov119_x1", o_x1, 153);
        chk("ov119_y1", o_y1, 471);
        cyc();
`ifdef BALL_AUTOSERVE_EN
        chk("auto_end", o_endgame, 0);
        chk("auto_x1", o_x1, 316);
        chk("auto_y1", o_y1, 236);
        chk("auto_score", o_score, 1);
        i_ani_stb = 1'b0;
`else
        repeat (80) cyc();
        chk("ov200_end", o_endgame, 1);
        chk("ov200_x1", o_x1, 153);
        i_ani_stb = 1'b0;
        serve();
        chk("restart_end", o_endgame, 0);
        chk("restart_x1", o_x1, 316);
        chk("restart_y1", o_y1, 236);
        chk("restart_score", o_score, 1);
`endif
        chk("miss_no_hit", hits, 0);
        serve();
        chk("serve_clr_score", o_score, 0);

        // animate low, start ignored in PLAY, reset mid-PLAY
        do_reset();
        serve();
        steps(5);
        i_ani_stb = 1'b1;
        i_animate = 1'b0;
        repeat (50) cyc();
        chk("anim0_x1", o_x1, 321);
        chk("anim0_y1", o_y1, 241);
        i_ani_stb = 1'b0;
        i_start = 1'b1;
        repeat (3) cyc();
        i_start = 1'b0;
        chk("play_start_x1", o_x1, 321);
        chk("play_start_end", o_endgame, 0);
        steps(1);
        chk("play_start_step", o_x1, 322);
        i_ani_stb = 1'b1;
        i_start = 1'b1;
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        i_start = 1'b0;
        i_ani_stb = 1'b0;
        chk("midrst_x1", o_x1, 316);
        chk("midrst_y1", o_y1, 236);
        chk("midrst_score", o_score, 0);
        steps(3);
        chk("midrst_idle", o_x1, 316);

        // random stimulus against the model
        pa = 0; pb = 60; pc = 440;
        set_pad(pa, pb, pc);
        do_reset();
        model_step(1, 0, 0, 0, pa, pb, pc);
        for (int c = 0; c < 30000; c++) begin
            if (c % 400 == 0) begin
                pa = $urandom_range(0, 600);
                pb = pa + $urandom_range(0, 120);
                pc = $urandom_range(200, 500);
            end
            rr = ($urandom_range(0, 9999) == 0);
            ss = ($urandom_range(0, 2) != 0);
            aa = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 199) == 0);
            set_pad(pa, pb, pc);
            i_rst = rr;
            i_ani_stb = ss;
            i_animate = aa;
            i_start = st;
            cyc();
            model_step(rr, ss, aa, st, pa, pb, pc);
            chk("r_x1", o_x1, mx - B);
            chk("r_x2", o_x2, mx + B);
            chk("r_y1", o_y1, my - B);
            chk("r_y2", o_y2, my + B);
            chk("r_hit", o_hit, mhit);
            chk("r_score", o_score, mscore);
            chk("r_end", o_endgame, int'(mmode == 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
